led_pulse_stretcher: RTL and testbench
======================================

LED_PULSE_STRETCHER -- requirements
Module: led_pulse_stretcher

Interface
REQ-001 Parameter ON_CYCLES, default 8, sets LED on-time per pulse in clk cycles; legal range is 1 or more.
REQ-002 Parameter GAP_CYCLES, default 4, sets the minimum LED off-time after every pulse in clk cycles; legal range is 1 or more.
REQ-003 Parameter PEND_W, default 3, sets the pending-event counter width, so the saturation value is 2^PEND_W-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 EVENT  input  1  event strobe; each cycle sampled high counts as one event.
REQ-007 LED  output  1  registered stretched pulse output.
REQ-008 BUSY  output  1  registered; high whenever the state is not IDLE.
REQ-009 PENDING  output  PEND_W  registered count of queued events not yet displayed.
REQ-010 OVERFLOW  output  1  registered sticky flag; an event was lost to saturation.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ON and GAP.
REQ-012 The internal timer width SHALL be clog2(max(ON_CYCLES,GAP_CYCLES))+1 bits, and the timer SHALL never wrap.
REQ-013 In IDLE with EVENT=1, the FSM SHALL enter ON at the next edge, so LED and BUSY rise with 1-cycle latency; PENDING SHALL be unchanged.
REQ-014 In ON, LED SHALL be 1 for exactly ON_CYCLES cycles, then the FSM SHALL enter GAP.
REQ-015 In GAP, LED SHALL be 0 for exactly GAP_CYCLES cycles; at the end, PENDING>0 SHALL give ON with PENDING-1, and PENDING=0 SHALL give IDLE.
REQ-016 In ON or GAP, EVENT=1 SHALL increment PENDING, except as REQ-018 states.
REQ-017 At saturation (PENDING=2^PEND_W-1), EVENT=1 in ON or GAP SHALL leave PENDING unchanged and set OVERFLOW=1 until rst.
REQ-018 In the final GAP cycle, EVENT=1 SHALL cancel the decrement: the FSM enters ON, PENDING is unchanged (including at 0 or at saturation), and OVERFLOW is not set.
REQ-019 In the final ON cycle, EVENT=1 SHALL be queued per REQ-016/REQ-017.
REQ-020 Back-to-back pulses SHALL always be separated by exactly GAP_CYCLES low cycles, and LED SHALL never be high for fewer than ON_CYCLES consecutive cycles, except when cut by rst.
REQ-021 BUSY SHALL equal 1 from the cycle LED first rises through the last GAP cycle of the final pulse.

Reset
REQ-022 When rst=1 at a rising edge, the next state SHALL be IDLE with LED=0, BUSY=0, PENDING=0, OVERFLOW=0 and timer=0.
REQ-023 EVENT SHALL be ignored in any cycle where rst=1.
REQ-024 rst SHALL take priority over every other transition, including mid-ON, mid-GAP and a simultaneous EVENT.
REQ-025 All outputs SHALL be defined from the first edge with rst=1; there is no dependence on power-up state.

Verification (defaults: ON=8, GAP=4, PEND_W=3; cycle 0 = first EVENT sample)
REQ-026 Single event: one EVENT pulse at cycle 0 from IDLE -> LED=1 cycles 1-8, LED=0 cycles 9-12, BUSY=1 cycles 1-12, IDLE at cycle 13, PENDING stays 0.
REQ-027 Queued events: EVENT at cycle 0 plus cycles 2, 3, 4 -> PENDING=3 by cycle 5, four pulses at LED rises on cycles 1, 13, 25, 37, PENDING decrementing 2, 1, 0 at each restart, BUSY low from cycle 49.
REQ-028 Saturation: EVENT held high cycles 0-9 -> PENDING reaches 7 at cycle 8, OVERFLOW=1 from cycle 9, PENDING stays 7; EVENT low from cycle 10 -> eight pulses total, then OVERFLOW still 1.
REQ-029 Final-gap collision: single event at cycle 0, then EVENT=1 at cycle 12 only -> LED rises at cycle 13 with no IDLE cycle, PENDING=0 throughout, OVERFLOW=0.
REQ-030 Reset mid-pulse: events at cycles 0, 2, 3, then rst=1 at cycle 5 with EVENT=1 -> at cycle 6 LED=0, BUSY=0, PENDING=0, OVERFLOW=0; no further pulses follow.

Source files
------------

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width LED pulses separated by a minimum gap.
// Events that arrive during a pulse are queued in a saturating counter and replayed one pulse each.
module led_pulse_stretcher #(
    parameter int ON_CYCLES  = 8,
    parameter int GAP_CYCLES = 4,
    parameter int PEND_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EVENT,
    output logic              LED,
    output logic              BUSY,
    output logic [PEND_W-1:0] PENDING,
    output logic              OVERFLOW
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0]     ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;
    logic              queue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            PENDING  <= '0;
            OVERFLOW <= 1'b0;
            LED      <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            PENDING  <= pend_nxt;
            OVERFLOW <= ovf_nxt;
            LED      <= (state_nxt == ON);
            BUSY     <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pend_nxt  = PENDING;
        ovf_nxt   = OVERFLOW;
        queue     = 1'b0;

        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (EVENT) state_nxt = ON;
            end
            ON: begin
                queue = EVENT;
                if (timer == ON_LAST) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_nxt = '0;
                    // A fresh event here starts the next pulse directly instead of being queued.
                    if (EVENT) begin
                        state_nxt = ON;
                    end else if (PENDING != '0) begin
                        state_nxt = ON;
                        pend_nxt  = PENDING - PEND_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    queue     = EVENT;
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase

        if (queue) begin
            if (PENDING == PEND_MAX) ovf_nxt  = 1'b1;
            else                     pend_nxt = PENDING + PEND_W'(1);
        end
    end

    a_busy_state : assert property (@(posedge clk) disable iff (rst)
        BUSY == (state != IDLE));
    a_led_state : assert property (@(posedge clk) disable iff (rst)
        LED == (state == ON));
    a_timer_on : assert property (@(posedge clk) disable iff (rst)
        (state == ON) |-> (timer <= ON_LAST));
    a_timer_gap : assert property (@(posedge clk) disable iff (rst)
        (state == GAP) |-> (timer <= GAP_LAST));
    a_ovf_sticky : assert property (@(posedge clk) disable iff (rst)
        OVERFLOW |=> OVERFLOW);

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Randomized and directed stimulus against a cycle-offset reference model of the pulse stretcher.
module tb_led_pulse_stretcher;

    localparam int ON   = 8;
    localparam int GAP  = 4;
    localparam int PW   = 3;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          EVENT;
    logic          LED;
    logic          BUSY;
    logic [PW-1:0] PENDING;
    logic          OVERFLOW;

    int errs   = 0;
    int checks = 0;

    // Reference state: a pulse is described by the cycle its LED rose.
    bit m_busy;
    int m_start;
    int m_pend;
    bit m_ovf;
    int cyc = 0;

    led_pulse_stretcher #(.ON_CYCLES(ON), .GAP_CYCLES(GAP), .PEND_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .EVENT    (EVENT),
        .LED      (LED),
        .BUSY     (BUSY),
        .PENDING  (PENDING),
        .OVERFLOW (OVERFLOW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit e);
        int off;
        if (r) begin
            m_busy = 1'b0;
            m_pend = 0;
            m_ovf  = 1'b0;
        end else if (!m_busy) begin
            if (e) begin
                m_busy  = 1'b1;
                m_start = cyc + 1;
            end
        end else begin
            off = cyc - m_start;
            if (off == ON + GAP - 1) begin
                if (e) begin
                    m_start = cyc + 1;
                end else if (m_pend > 0) begin
                    m_pend--;
                    m_start = cyc + 1;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (e) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else                m_pend++;
            end
        end
    endtask

    task automatic step(input bit r, input bit e);
        bit exp_led;
        @(negedge clk);
        rst   = r;
        EVENT = e;
        @(posedge clk);
        model_edge(r, e);
        cyc++;
        #1;
        exp_led = m_busy && ((cyc - m_start) < ON);
        chk("led",      32'(LED),      32'(exp_led));
        chk("busy",     32'(BUSY),     32'(m_busy));
        chk("pending",  32'(PENDING),  32'(m_pend));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
    endtask

    // Drive a pattern of event cycles starting from a clean reset; cycle 0 is bit 0.
    task automatic run_pattern(input logic [63:0] evs, input int len, input int rst_at);
        step(1'b1, 1'b1);
        for (int i = 0; i < len; i++) begin
            step(i == rst_at, (i < 64) ? evs[i] : 1'b0);
        end
    endtask

    initial begin
        logic [63:0] pat;
        int          p;
        rst   = 1'b1;
        EVENT = 1'b0;

        step(1'b1, 1'b1);
        chk("rst_led",  32'(LED),      32'd0);
        chk("rst_busy", 32'(BUSY),     32'd0);
        chk("rst_pend", 32'(PENDING),  32'd0);
        chk("rst_ovf",  32'(OVERFLOW), 32'd0);

        // Single event
        pat = 64'h1;
        run_pattern(pat, 20, -1);

        // Queued events at 0,2,3,4
        pat = 64'h1D;
        run_pattern(pat, 55, -1);
        chk("queue_idle", 32'(BUSY), 32'd0);

        // Saturation: EVENT held cycles 0-9
        pat = 64'h3FF;
        run_pattern(pat, 8 * (ON + GAP) + 6, -1);
        chk("sat_ovf_sticky", 32'(OVERFLOW), 32'd1);
        chk("sat_idle",       32'(BUSY),     32'd0);

        // Final-gap collision at cycle 12
        pat = 64'h1001;
        run_pattern(pat, 30, -1);

        // Reset mid-pulse with simultaneous event
        pat = 64'h2D;
        run_pattern(pat, 30, 5);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);

        // Random traffic with varying density and occasional resets
        for (int blk = 0; blk < 12; blk++) begin
            p = $urandom_range(5, 90);
            for (int i = 0; i < 250; i++) begin
                step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < p);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
